// File: rtl/rc4_ksa_engine_if.sv
// RC4 KSA engine bus: control handshake plus the shared S RAM port.
// The master side is the KSA engine, which drives the S RAM while it owns the mux.
interface rc4_ksa_engine_if #(
    parameter int KEY_BYTES = 3
);
    logic                   start_sig;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic                   abort;
    logic [7:0]             q_data;
    logic [7:0]             address;
    logic [7:0]             data;
    logic                   wen;
    logic                   ksa_mem_handler;
    logic                   finish;

    modport master (
        input  start_sig,
        input  secret_key,
        input  abort,
        input  q_data,
        output address,
        output data,
        output wen,
        output ksa_mem_handler,
        output finish
    );

    modport slave (
        output start_sig,
        output secret_key,
        output abort,
        output q_data,
        input  address,
        input  data,
        input  wen,
        input  ksa_mem_handler,
        input  finish
    );
endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: fills S[i]=i, then runs the KSA swap loop over
// the shared S RAM. RAM reads take two cycles (address in SETUP, held in
// READ, data captured in SAMPLE). Outputs decode state and datapath registers.
module rc4_ksa_engine #(
    parameter int KEY_BYTES = 3
) (
    input  logic                clk,
    input  logic                reset,
    rc4_ksa_engine_if.master    bus
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INIT     = 4'd1,
        ST_SETUP_I  = 4'd2,
        ST_READ_I   = 4'd3,
        ST_SAMPLE_I = 4'd4,
        ST_ADD_J    = 4'd5,
        ST_SETUP_J  = 4'd6,
        ST_READ_J   = 4'd7,
        ST_SAMPLE_J = 4'd8,
        ST_WRITE_I  = 4'd9,
        ST_WRITE_J  = 4'd10,
        ST_NEXT     = 4'd11,
        ST_DONE     = 4'd12
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             i_q, i_d;
    logic [7:0]             j_q, j_d;
    logic [KW-1:0]          key_idx_q, key_idx_d;
    logic [7:0]             temp_i_q, temp_i_d;
    logic [7:0]             temp_j_q, temp_j_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;

    // Key byte 0 is the most significant byte of the latched key.
    function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                            input logic [KW-1:0] idx);
        logic [8*KEY_BYTES-1:0] sh;
        sh = key >> (8 * (KEY_BYTES - 1 - int'(idx)));
        return sh[7:0];
    endfunction

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            key_idx_q <= '0;
            temp_i_q  <= 8'd0;
            temp_j_q  <= 8'd0;
            key_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            key_idx_q <= key_idx_d;
            temp_i_q  <= temp_i_d;
            temp_j_q  <= temp_j_d;
            key_q     <= key_d;
        end
    end

    // Next-state and datapath update; abort overrides any active state.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        key_idx_d = key_idx_q;
        temp_i_d  = temp_i_q;
        temp_j_d  = temp_j_q;
        key_d     = key_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_sig) begin
                    key_d     = bus.secret_key;
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    key_idx_d = '0;
                    state_d   = ST_INIT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_INIT: begin
                i_d = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    state_d = ST_SETUP_I;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_SETUP_I:  state_d = ST_READ_I;
            ST_READ_I:   state_d = ST_SAMPLE_I;
            ST_SAMPLE_I: begin
                temp_i_d = bus.q_data;
                state_d  = ST_ADD_J;
            end
            ST_ADD_J: begin
                j_d     = j_q + temp_i_q + key_byte(key_q, key_idx_q);
                state_d = ST_SETUP_J;
            end
            ST_SETUP_J:  state_d = ST_READ_J;
            ST_READ_J:   state_d = ST_SAMPLE_J;
            ST_SAMPLE_J: begin
                temp_j_d = bus.q_data;
                state_d  = ST_WRITE_I;
            end
            ST_WRITE_I:  state_d = ST_WRITE_J;
            ST_WRITE_J:  state_d = ST_NEXT;
            ST_NEXT: begin
                if (i_q == 8'd255) begin
                    state_d = ST_DONE;
                end else begin
                    i_d       = i_q + 8'd1;
                    key_idx_d = (key_idx_q == KIDX_LAST) ? '0 : key_idx_q + KW'(1);
                    state_d   = ST_SETUP_I;
                end
            end
            ST_DONE: begin
                if (bus.start_sig) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode: RAM port and status flags from state and datapath.
    always_comb begin
        bus.address         = 8'd0;
        bus.data            = 8'd0;
        bus.wen             = 1'b0;
        bus.ksa_mem_handler = 1'b0;
        bus.finish          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.ksa_mem_handler = 1'b0;
            end
            ST_INIT: begin
                bus.ksa_mem_handler = 1'b1;
                bus.wen             = 1'b1;
                bus.address         = i_q;
                bus.data            = i_q;
            end
            ST_SETUP_I, ST_READ_I, ST_SAMPLE_I, ST_NEXT: begin
                bus.ksa_mem_handler = 1'b1;
                bus.address         = i_q;
            end
            ST_ADD_J: begin
                bus.ksa_mem_handler = 1'b1;
            end
            ST_SETUP_J, ST_READ_J, ST_SAMPLE_J: begin
                bus.ksa_mem_handler = 1'b1;
                bus.address         = j_q;
            end
            ST_WRITE_I: begin
                bus.ksa_mem_handler = 1'b1;
                bus.wen             = 1'b1;
                bus.address         = i_q;
                bus.data            = temp_j_q;
            end
            ST_WRITE_J: begin
                bus.ksa_mem_handler = 1'b1;
                bus.wen             = 1'b1;
                bus.address         = j_q;
                bus.data            = temp_i_q;
            end
            ST_DONE: begin
                bus.finish = 1'b1;
            end
            default: begin
                bus.finish = 1'b0;
            end
        endcase
    end
endmodule
